// File: rtl/parking_lot_sensor_counter_pkg.sv
// parking_pkg: shared widths, default capacity and FSM state encoding
package parking_pkg;
  localparam int COUNT_W = 5;
  localparam int DEFAULT_MAX_COUNT = 16;
  typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3} state_t;
endpackage

// File: rtl/occupancy_counter.sv
// occupancy_counter: saturating up/down occupancy count with registered full/empty flags
module occupancy_counter
  import parking_pkg::*;
#(
  parameter int MAX_COUNT = DEFAULT_MAX_COUNT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               dec,
  output logic [COUNT_W-1:0] count,
  output logic               full,
  output logic               empty
);
  localparam logic [COUNT_W-1:0] MAX = COUNT_W'(MAX_COUNT);
  logic [COUNT_W-1:0] nxt;
  // next count, holding at either end of the range
  always_comb nxt = (inc && count != MAX) ? count + 1'b1 : (dec && count != '0) ? count - 1'b1 : count;
  // flags come from the next count so they change on the same edge as the count
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      count <= nxt;
      full  <= nxt == MAX;
      empty <= nxt == '0;
    end
endmodule

// File: rtl/parking_lot_sensor_counter.sv
// parking_lot_sensor_counter: synchronizes gate sensors, decodes car direction, tracks occupancy
module parking_lot_sensor_counter
  import parking_pkg::*;
#(
  parameter int MAX_COUNT = DEFAULT_MAX_COUNT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               a,
  input  logic               b,
  output logic [COUNT_W-1:0] counterstate,
  output logic               enter,
  output logic               exit,
  output logic               full,
  output logic               empty
);
  logic [1:0] s1, s;
  state_t state, nxt;
  logic done_en, done_ex;
  // two-flop synchronizer on the {a,b} pair
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1 <= 2'b00;
      s  <= 2'b00;
    end else begin
      s1 <= {a, b};
      s  <= s1;
    end
  // direction decoder; any all-clear drops back to IDLE, skipped steps abort
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE: nxt = s == 2'b10 ? EN1 : s == 2'b01 ? EX1 : IDLE;
      EN1:  nxt = s == 2'b10 ? EN1 : s == 2'b11 ? EN2 : IDLE;
      EN2:  nxt = s == 2'b11 ? EN2 : s == 2'b01 ? EN3 : s == 2'b10 ? EN1 : IDLE;
      EN3:  nxt = s == 2'b01 ? EN3 : s == 2'b11 ? EN2 : IDLE;
      EX1:  nxt = s == 2'b01 ? EX1 : s == 2'b11 ? EX2 : IDLE;
      EX2:  nxt = s == 2'b11 ? EX2 : s == 2'b10 ? EX3 : s == 2'b01 ? EX1 : IDLE;
      EX3:  nxt = s == 2'b10 ? EX3 : s == 2'b11 ? EX2 : IDLE;
      default: nxt = IDLE;
    endcase
  end
  assign done_en = state == EN3 && s == 2'b00;
  assign done_ex = state == EX3 && s == 2'b00;
  // state register and completion pulses, aligned with the count update
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      enter <= 1'b0;
      exit  <= 1'b0;
    end else begin
      state <= nxt;
      enter <= done_en;
      exit  <= done_ex;
    end
  occupancy_counter #(.MAX_COUNT(MAX_COUNT)) u_cnt (
    .clk(clk),
    .reset(reset),
    .inc(done_en),
    .dec(done_ex),
    .count(counterstate),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_parking_lot_sensor_counter.sv
// tb_parking_lot_sensor_counter: table vectors, corner sequences and randomized traffic against a progress model
module tb_parking_lot_sensor_counter;
  localparam int MAX = 16;
  logic clk = 0, reset, a, b;
  logic [4:0] counterstate;
  logic enter, exit, full, empty;
  int checks = 0, errors = 0;
  int pos, dir, mcount, en_seen, ex_seen;
  bit me, mx;
  logic [1:0] d1, d2;
  typedef struct {
    logic [7:0] seq;
    int cnt;
    int en;
    int ex;
  } vec_t;
  vec_t tbl [8];

  parking_lot_sensor_counter #(.MAX_COUNT(MAX)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .counterstate(counterstate),
    .enter(enter), .exit(exit), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  // position of a blocked pattern along a car's path in the given direction
  function automatic int idx(input logic [1:0] v, input int d);
    return v == 2'b11 ? 2 : ((v == 2'b10) == (d > 0)) ? 1 : 3;
  endfunction

  // a car advances one step at a time; all-clear after the last step completes it
  task automatic model_edge(input logic [1:0] v);
    int k;
    me = 0;
    mx = 0;
    if (v == 2'b00) begin
      if (pos == 3) begin
        if (dir > 0) me = 1;
        else mx = 1;
      end
      pos = 0;
    end else if (pos == 0) begin
      if (v == 2'b10) begin dir = 1; pos = 1; end
      else if (v == 2'b01) begin dir = -1; pos = 1; end
    end else begin
      k = idx(v, dir);
      if (k - pos == 1 || pos - k == 1) pos = k;
      else if (k != pos) pos = 0;
    end
    if (me && mcount < MAX) mcount++;
    if (mx && mcount > 0) mcount--;
  endtask

  task automatic model_reset();
    pos = 0; dir = 0; mcount = 0; me = 0; mx = 0; d1 = 0; d2 = 0;
  endtask

  // sensors seen by the decoder lag the pins by two edges
  task automatic cyc(input logic [1:0] v);
    {a, b} = v;
    @(posedge clk);
    model_edge(d2);
    d2 = d1;
    d1 = v;
    #1;
    chk("count", counterstate, mcount);
    chk("enter", enter, me);
    chk("exit", exit, mx);
    chk("full", full, mcount == MAX);
    chk("empty", empty, mcount == 0);
    if (enter) en_seen++;
    if (exit) ex_seen++;
  endtask

  task automatic hold(input logic [1:0] v, input int n);
    for (int i = 0; i < n; i++) cyc(v);
  endtask

  task automatic car(input bit entry, input int n);
    hold(entry ? 2'b10 : 2'b01, n);
    hold(2'b11, n);
    hold(entry ? 2'b01 : 2'b10, n);
    hold(2'b00, n);
  endtask

  task automatic do_reset();
    a = 0;
    b = 0;
    reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #4 reset = 0;
  endtask

  initial begin
    tbl[0] = '{8'b10_11_01_00, 1, 1, 0};
    tbl[1] = '{8'b10_11_10_00, 1, 0, 0};
    tbl[2] = '{8'b01_11_10_00, 0, 0, 1};
    tbl[3] = '{8'b10_01_00_00, 0, 0, 0};
    tbl[4] = '{8'b01_11_10_00, 0, 0, 1};
    tbl[5] = '{8'b10_11_01_00, 1, 1, 0};
    tbl[6] = '{8'b01_10_00_00, 1, 0, 0};
    tbl[7] = '{8'b01_11_01_00, 1, 0, 0};
    a = 0;
    b = 0;
    reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", counterstate, 0);
    chk("rst_enter", enter, 0);
    chk("rst_exit", exit, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    #3 reset = 0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] sq;
      sq = tbl[i].seq;
      en_seen = 0;
      ex_seen = 0;
      for (int j = 0; j < 4; j++) hold(sq[7-2*j -: 2], 4);
      hold(2'b00, 2);
      chk($sformatf("vec%0d_count", i), counterstate, tbl[i].cnt);
      chk($sformatf("vec%0d_enters", i), en_seen, tbl[i].en);
      chk($sformatf("vec%0d_exits", i), ex_seen, tbl[i].ex);
      chk($sformatf("vec%0d_empty", i), empty, tbl[i].cnt == 0);
    end
    hold(2'b10, 3);
    #3 reset = 1;
    a = 0;
    model_reset();
    #1;
    chk("async_rst_count", counterstate, 0);
    chk("async_rst_enter", enter, 0);
    chk("async_rst_exit", exit, 0);
    chk("async_rst_full", full, 0);
    chk("async_rst_empty", empty, 1);
    @(posedge clk);
    #4 reset = 0;
    hold(2'b00, 6);
    chk("post_rst_count", counterstate, 0);
    en_seen = 0;
    for (int i = 0; i < 5; i++) car(1, 1);
    hold(2'b00, 3);
    chk("b2b_count", counterstate, 5);
    chk("b2b_enters", en_seen, 5);
    do_reset();
    en_seen = 0;
    for (int i = 0; i < 18; i++) car(1, 2);
    hold(2'b00, 3);
    chk("sat_count", counterstate, 16);
    chk("sat_full", full, 1);
    chk("sat_enters", en_seen, 18);
    car(0, 2);
    hold(2'b00, 3);
    chk("unsat_count", counterstate, 15);
    chk("unsat_full", full, 0);
    do_reset();
    ex_seen = 0;
    car(0, 3);
    hold(2'b00, 3);
    chk("floor_count", counterstate, 0);
    chk("floor_empty", empty, 1);
    chk("floor_exits", ex_seen, 1);
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: car(1, $urandom_range(1, 3));
        1: car(0, $urandom_range(1, 3));
        2: for (int j = 0; j < 4; j++) hold(2'($urandom_range(0, 3)), $urandom_range(1, 3));
        default: hold(2'b00, $urandom_range(1, 3));
      endcase
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/parking_lot_sensor_counter.md
# parking_lot_sensor_counter

Tracks lot occupancy from two beam-break sensors and produces the 5-bit `counterstate` consumed by the occupancy HEX display driver. Sensor `a` sits on the outer side of the gate and `b` on the inner side. A full a→ab→b→none sequence is one car entering; b→ab→a→none is one car exiting. The block synchronizes the raw sensor pins, decodes direction with an FSM, and maintains a saturating up/down count.

## Interface
- `MAX_COUNT`, 16: lot capacity. Legal range 1..31; the count saturates here.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `a`  in  1  outer sensor, 1 = beam blocked. Asynchronous to `clk`.
- `b`  in  1  inner sensor, 1 = beam blocked. Asynchronous to `clk`.
- `counterstate`  out  5  current occupancy, 0..MAX_COUNT, registered.
- `enter`  out  1  one-cycle pulse on each completed entry.
- `exit`  out  1  one-cycle pulse on each completed exit.
- `full`  out  1  `counterstate == MAX_COUNT`, registered.
- `empty`  out  1  `counterstate == 0`, registered.

## Operation
- **Synchronizer:** `a` and `b` each pass through a two-flop synchronizer. The FSM sees only the synchronized pair `{as,bs}`.
- **FSM states:** IDLE, EN1, EN2, EN3, EX1, EX2, EX3. Input pairs below are written `{as,bs}`.
- **IDLE:**
  - 10 → EN1
  - 01 → EX1
  - 00 or 11 → stay
- **EN1:**
  - 10 → stay
  - 11 → EN2
  - 00 → IDLE (abort)
  - 01 → IDLE (illegal)
- **EN2:**
  - 11 → stay
  - 01 → EN3
  - 10 → EN1 (backing out)
  - 00 → IDLE
- **EN3:**
  - 01 → stay
  - 11 → EN2
  - 00 → IDLE, and assert `enter`
  - 10 → IDLE (illegal)
- **EX1/EX2/EX3:** mirror EN1/EN2/EN3 with `a` and `b` swapped. EX3 with 00 → IDLE and asserts `exit`.
- **Counter:**
  - `enter` increments the count unless it is at MAX_COUNT; at MAX_COUNT the count holds and `enter` still pulses.
  - `exit` decrements the count unless it is at 0; at 0 the count holds and `exit` still pulses.
  - `enter` and `exit` are mutually exclusive by construction; the counter need not handle both at once.
- A pedestrian or car that backs out before completing the sequence returns the FSM to IDLE without pulsing or changing the count.

## Timing
- **Reset values:** sync flops 0, state IDLE, `counterstate`=0, `enter`=0, `exit`=0, `full`=0, `empty`=1. Reset takes effect immediately regardless of `clk`.
- **Reset mid-sequence:** the partial sequence is discarded. After reset releases, the FSM restarts from IDLE with whatever the sensors are then showing.
- **Input-to-FSM latency:** a sensor value first captured at edge E0 reaches the FSM input after E1 and drives the state transition at E2.
- **Completion timing:** on the edge E2 that transitions EN3→IDLE:
  - `enter` is high for exactly the one cycle following E2.
  - `counterstate` takes its new value at E2, i.e., the same edge that raises `enter`.
  - `full` and `empty` are updated at the same edge as `counterstate`, with no extra cycle of lag.
- **Back-to-back cars:** a new sequence may begin on the cycle immediately after returning to IDLE.
- **Sensor pulses:** any sensor pulse shorter than one `clk` period may be missed. This is acceptable.

## Structure
- **Package `parking_pkg`:** holds the `state_t` enum for the seven states, `COUNT_W = 5`, and `DEFAULT_MAX_COUNT = 16`.
- **Sub-module `occupancy_counter`:** the saturating up/down counter. Inputs `clk`, `reset`, `inc`, `dec`; outputs `count`, `full`, `empty`; parameter `MAX_COUNT`.
- **Top level:** the synchronizer and FSM live in the top module, which instantiates `occupancy_counter`.

## Test plan
- **Reset:** assert `reset` mid-cycle with `a`=1 → all outputs go to their reset values immediately, without waiting for a clock edge. After release, hold `a=b=0` → FSM stays IDLE and `counterstate`=0.
- **Single entry:** drive `{a,b}` = 10, 11, 01, 00, each held 4 cycles → exactly one `enter` pulse. It appears 2 edges after 00 is first sampled, and `counterstate` goes 0→1 on the same edge.
- **Aborted entry:** drive 10, 11, 10, 00 → no pulse and `counterstate` unchanged. Then drive 01, 11, 10, 00 from count 1 → one `exit` pulse and count 1→0.
- **Saturation:** run 18 complete entries with MAX_COUNT=16 → count stops at 16 and `full`=1, with 18 `enter` pulses. Then one exit → count 15 and `full`=0. Separately, an exit at count 0 → count stays 0, `empty`=1, and `exit` pulses.
- **Illegal sequence:** drive 10, 01, 00 → returns to IDLE with no pulse and no count change.
- **Back-to-back entries:** run 5 consecutive entries with no idle gap beyond the 00 step → count 5 and 5 distinct `enter` pulses.
